pipelined_cla_addsub: RTL and testbench
=======================================

Name: pipelined_cla_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the KGP-RISC ALU datapath.
- Splits WIDTH into GROUP-bit lookahead groups; each pipeline stage resolves GROUPS_PER_STAGE groups, with the group carry rippling between stages.
- Adds a subtract mode, signed/unsigned flags, and a valid/ready handshake with global stall.
- Sits between the operand-fetch registers and ALU result mux.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of GROUP*GROUPS_PER_STAGE
GROUP, 4, bits per lookahead group
GROUPS_PER_STAGE, 2, groups resolved per pipeline stage
(derived) LAT = WIDTH/(GROUP*GROUPS_PER_STAGE), pipeline depth in cycles (32/8 = 4 by default)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in, used only when sub=0
sub  input  1  1 = A-B (two's complement), 0 = A+B+cin
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out; for sub, 1 = no borrow (A>=B unsigned)
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
zero  output  1  sum == 0
neg  output  1  sum[WIDTH-1]

Behaviour:
- Reset: all stage valid bits 0, out_valid=0, sum=0, cout=0, ovf=0, zero=0, neg=0. Reset mid-operation discards every in-flight beat; no beat emerges afterwards.
- Operand conditioning at input: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Advance enable: en = ~out_valid | out_ready. in_ready = en, combinational, with no dependence on in_valid.
- Global stall: when en=0, every pipeline register holds. When en=1, all stages shift one place and stage 0 loads {in_valid, conditioned operands}.
- Bubbles are not compressed.
- A beat is accepted iff in_valid & in_ready. A result is consumed iff out_valid & out_ready.
- Throughput: 1 beat/cycle when out_ready is held high. Latency from acceptance to out_valid is exactly LAT cycles.
- Stage k (0..LAT-1) operates on bit slice [k*S +: S], with S = GROUP*GROUPS_PER_STAGE:
  - Per group: p_i = a_i^b_i, g_i = a_i&b_i, with full lookahead carries inside the group (no ripple inside the group).
  - Group G/P feed a lookahead over the stage's groups; the stage carry-out is registered for stage k+1.
- Skew registers:
  - Upper, unprocessed operand slices travel down the pipeline unchanged.
  - Completed lower sum slices are delayed so all WIDTH sum bits are aligned at the output register.
- Final stage computes flags before its output register:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR cout.
  - zero = ~|sum. neg = sum[WIDTH-1].
  - All outputs are registered. Output data holds stable while out_valid & ~out_ready.
- Simultaneous accept and consume in one cycle is legal and loses no beat.
- Wrap-around: arithmetic is modulo 2^WIDTH.
- Boundary cases:
  - a=b=0, sub=1 gives sum=0, cout=1, zero=1.
  - Most-negative minus 1 sets ovf.
- in_valid with in_ready=0 is ignored; the source must hold the beat.

Decomposition:
- Shared ALU package/header holds:
  - the LAT/stage-width computation as a constant function or macro;
  - the flag bit positions {cout, ovf, zero, neg} used by the ALU flag register.
- One natural sub-module: cla_group (GROUP-bit lookahead: inputs a, b, c_in; outputs sum, group G, group P).
- The top module instantiates WIDTH/GROUP copies via generate and owns the pipeline, skew and handshake logic.

Test Plan:
- Reset, then in_valid pulses a=0x0000_0005, b=0x0000_0003, sub=0, cin=0, out_ready=1 -> out_valid exactly 4 cycles later with sum=0x8, cout=0, ovf=0, zero=0, neg=0.
- a=0xFFFF_FFFF, b=0x1, sub=0 (full carry chain across all stages) -> sum=0, cout=1, zero=1, ovf=0.
- Signed overflow:
  - a=0x7FFF_FFFF, b=0x1, add -> sum=0x8000_0000, ovf=1, neg=1, cout=0.
  - a=0x8000_0000, b=0x1, sub -> sum=0x7FFF_FFFF, ovf=1, cout=1.
- Subtract borrow: a=3, b=5, sub=1 -> sum=0xFFFF_FFFE, cout=0, neg=1.
- Stall and throughput:
  - Stream 8 back-to-back beats (a=i, b=i) with out_ready low for cycles 6-9.
  - Required: in_ready falls while out_valid & ~out_ready; outputs hold; no beat is lost or duplicated; results arrive in order as 2i.
- Assert rst for one cycle with 3 beats in flight -> out_valid=0 and all outputs 0 next cycle; no stale beat appears over the following 4 cycles.

Source files
------------

// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor
// and the ALU flag register that consumes its flags.
package pipelined_cla_addsub_pkg;

  // Flag bit positions in the ALU flag register: {cout, ovf, zero, neg}
  localparam int unsigned FLAG_NEG  = 0;
  localparam int unsigned FLAG_ZERO = 1;
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_COUT = 3;
  localparam int unsigned FLAG_BITS = 4;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } alu_flags_t;

  function automatic int unsigned stage_width(input int unsigned group,
                                              input int unsigned groups_per_stage);
    return group * groups_per_stage;
  endfunction

  function automatic int unsigned calc_lat(input int unsigned width,
                                           input int unsigned group,
                                           input int unsigned groups_per_stage);
    return width / stage_width(group, groups_per_stage);
  endfunction

endpackage

// File: rtl/pipelined_cla_addsub_cla_group.sv
// GROUP-bit carry-lookahead block: flattened carries inside the group plus
// group generate/propagate for the next lookahead level.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c_in,
  output logic [GROUP-1:0] sum,
  output logic             g_grp,
  output logic             p_grp
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  always_comb begin
    logic run;
    logic acc;
    p     = a ^ b;
    g     = a & b;
    c     = '0;
    g_grp = 1'b0;
    // Each carry is a sum of products of g/p terms, never a chain through c[i-1]
    for (int unsigned i = 0; i <= GROUP; i++) begin
      run = 1'b1;
      acc = 1'b0;
      for (int unsigned n = 0; n < i; n++) begin
        acc = acc | (g[i-1-n] & run);
        run = run & p[i-1-n];
      end
      c[i] = acc | (run & c_in);
      if (i == GROUP) g_grp = acc;
    end
    p_grp = &p;
    sum   = p ^ c[GROUP-1:0];
  end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one S-bit slice resolved per stage,
// operand/sum skew registers, registered flags and a valid/ready global stall.
module pipelined_cla_addsub
  import pipelined_cla_addsub_pkg::*;
#(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned GROUP            = 4,
  parameter int unsigned GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned S   = stage_width(GROUP, GROUPS_PER_STAGE);
  localparam int unsigned LAT = calc_lat(WIDTH, GROUP, GROUPS_PER_STAGE);
  localparam int unsigned NG  = WIDTH / GROUP;

  logic             en;
  logic [LAT-1:0]   r_valid;
  logic [WIDTH-1:0] r_a [LAT];
  logic [WIDTH-1:0] r_b [LAT];
  logic [WIDTH-1:0] r_s [LAT];
  logic [LAT-1:0]   r_c;

  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_c;
  logic [WIDTH-1:0] grp_sum;
  logic [WIDTH-1:0] nxt_s [LAT];
  logic [LAT-1:0]   st_cout;

  logic [WIDTH-1:0] fin_sum;
  logic             fin_cout;
  logic             fin_ovf;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .a     (r_a[gi/GROUPS_PER_STAGE][gi*GROUP +: GROUP]),
      .b     (r_b[gi/GROUPS_PER_STAGE][gi*GROUP +: GROUP]),
      .c_in  (grp_c[gi]),
      .sum   (grp_sum[gi*GROUP +: GROUP]),
      .g_grp (grp_g[gi]),
      .p_grp (grp_p[gi])
    );
  end

  // Second lookahead level across the groups of each stage
  always_comb begin
    logic run;
    logic acc;
    int unsigned base;
    grp_c   = '0;
    st_cout = '0;
    for (int unsigned k = 0; k < LAT; k++) begin
      base = k * GROUPS_PER_STAGE;
      for (int unsigned j = 0; j <= GROUPS_PER_STAGE; j++) begin
        run = 1'b1;
        acc = 1'b0;
        for (int unsigned n = 0; n < j; n++) begin
          acc = acc | (grp_g[base+j-1-n] & run);
          run = run & grp_p[base+j-1-n];
        end
        if (j < GROUPS_PER_STAGE) grp_c[base+j] = acc | (run & r_c[k]);
        else                      st_cout[k]    = acc | (run & r_c[k]);
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < LAT; k++) begin
      nxt_s[k]          = r_s[k];
      nxt_s[k][k*S +: S] = grp_sum[k*S +: S];
    end
  end

  // Carry into the MSB recovered as p_msb ^ sum_msb
  assign fin_sum  = nxt_s[LAT-1];
  assign fin_cout = st_cout[LAT-1];
  assign fin_ovf  = fin_cout ^ (r_a[LAT-1][WIDTH-1] ^ r_b[LAT-1][WIDTH-1] ^ fin_sum[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (en) begin
      r_valid[0] <= in_valid;
      r_a[0]     <= a;
      r_b[0]     <= sub ? ~b : b;
      r_c[0]     <= sub ? 1'b1 : cin;
      r_s[0]     <= '0;
      for (int unsigned k = 1; k < LAT; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_a[k]     <= r_a[k-1];
        r_b[k]     <= r_b[k-1];
        r_s[k]     <= nxt_s[k-1];
        r_c[k]     <= st_cout[k-1];
      end
      out_valid <= r_valid[LAT-1];
      // Bubbles leave the previous result on the data outputs
      if (r_valid[LAT-1]) begin
        sum  <= fin_sum;
        cout <= fin_cout;
        ovf  <= fin_ovf;
        zero <= ~|fin_sum;
        neg  <= fin_sum[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub: vector table with latency checks,
// then a stalled stream and a mid-flight reset.
module tb_pipelined_cla_addsub;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LAT   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(WIDTH), .GROUP(4), .GROUPS_PER_STAGE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic [3:0]  flags; // {cout, ovf, zero, neg}
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [11];

  initial begin
    int cycles;
    int sent;
    int got;
    int c;
    logic held;
    logic [31:0] held_sum;
    logic acc;

    vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 4'b0000};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b1010};
    vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0101};
    vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b1100};
    vecs[4]  = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'b0001};
    vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 4'b1010};
    vecs[6]  = '{32'h0000_000F, 32'h0000_00F0, 1'b1, 1'b0, 32'h0000_0100, 4'b0000};
    vecs[7]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 4'b1000};
    vecs[8]  = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 4'b0001};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b1110};
    vecs[10] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 4'b0000};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_flags", 64'({cout, ovf, zero, neg}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 11; i++) begin
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cycles = 0;
      while (!out_valid && cycles < 20) begin
        tick();
        cycles++;
      end
      chk($sformatf("v%0d_latency", i), 64'(cycles), 64'(LAT));
      chk($sformatf("v%0d_sum", i), 64'(sum), 64'(vecs[i].sum));
      chk($sformatf("v%0d_flags", i), 64'({cout, ovf, zero, neg}), 64'(vecs[i].flags));
      tick();
      chk($sformatf("v%0d_single", i), 64'(out_valid), 64'd0);
    end

    // Stream of 8 beats, consumer stalls during cycles 6..9
    sent = 0; got = 0; held = 1'b0; held_sum = '0;
    sub = 1'b0; cin = 1'b0;
    for (c = 0; c < 60 && got < 8; c++) begin
      out_ready = !(c >= 6 && c <= 9);
      in_valid  = (sent < 8);
      a = 32'(sent); b = 32'(sent);
      #1;
      if (held) begin
        chk($sformatf("hold_valid_c%0d", c), 64'(out_valid), 64'd1);
        chk($sformatf("hold_sum_c%0d", c), 64'(sum), 64'(held_sum));
      end
      held = out_valid & ~out_ready;
      held_sum = sum;
      if (out_valid & ~out_ready)
        chk($sformatf("stall_in_ready_c%0d", c), 64'(in_ready), 64'd0);
      if (out_valid & out_ready) begin
        chk($sformatf("stream_sum_%0d", got), 64'(sum), 64'(2 * got));
        got++;
      end
      acc = in_valid & in_ready;
      @(posedge clk);
      if (acc) sent++;
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", 64'(got), 64'd8);
    repeat (6) begin
      tick();
      chk("stream_no_extra", 64'(out_valid), 64'd0);
    end

    // Three beats in flight, then a one-cycle reset
    for (int i = 0; i < 3; i++) begin
      a = 32'(i + 1); b = 32'h10; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_flags", 64'({cout, ovf, zero, neg}), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rst_no_stale_%0d", i), 64'(out_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
